// File: rtl/and_tree_pipe.sv
// Pipelined AND-reduction of per-slice TCAM match vectors, followed by a hit
// and lowest-index encode stage. All stages advance together under one enable.
module and_tree_pipe #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 16,
  parameter int FAN   = 6,
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [WIDTH*DEPTH-1:0] s_in,
  input  logic [WIDTH-1:0]       s_slice_en,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [DEPTH-1:0]       m_match,
  output logic                   m_hit,
  output logic [IDX_W-1:0]       m_index
);

  function automatic int calc_levels(int w, int f);
    int n;
    int lv;
    n  = w;
    lv = 0;
    if (f < 2) return 1;
    while (n > 1) begin
      n  = (n + f - 1) / f;
      lv = lv + 1;
    end
    return (lv < 1) ? 1 : lv;
  endfunction

  function automatic int items_at(int l);
    int n;
    int f;
    n = WIDTH;
    f = (FAN < 2) ? 2 : FAN;
    for (int i = 0; i < l; i++) n = (n + f - 1) / f;
    return n;
  endfunction

  localparam int LEVELS = calc_levels(WIDTH, FAN);

  if ((DEPTH % 4) != 0 || DEPTH < 4 || FAN < 2 || FAN > 6 || WIDTH < 1) begin : g_bad_param
    $error("and_tree_pipe: illegal parameters DEPTH=%0d WIDTH=%0d FAN=%0d", DEPTH, WIDTH, FAN);
  end

  logic                   en;
  logic [DEPTH-1:0]       masked [WIDTH];
  logic [DEPTH-1:0]       root;
  logic                   vld_root;
  logic                   hit_c;
  logic [IDX_W-1:0]       idx_c;

  assign en      = m_ready || !m_valid;
  assign s_ready = en;

  // A disabled slice becomes all-ones so it cannot clear any match bit.
  always_comb begin
    for (int k = 0; k < WIDTH; k++) begin
      masked[k] = s_in[k*DEPTH +: DEPTH] | {DEPTH{~s_slice_en[k]}};
    end
  end

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int NI = items_at(l);
    localparam int NO = items_at(l + 1);

    logic [DEPTH-1:0] din   [NI];
    logic [DEPTH-1:0] grp   [NO];
    logic [DEPTH-1:0] dat_p [NO];
    logic             vld_in;
    logic             vld_p;

    if (l == 0) begin : g_src
      assign din    = masked;
      assign vld_in = s_valid;
    end else begin : g_src
      assign din    = g_lvl[l-1].dat_p;
      assign vld_in = g_lvl[l-1].vld_p;
    end

    // Inputs beyond the end of the last group act as all-ones.
    always_comb begin
      for (int j = 0; j < NO; j++) begin
        grp[j] = '1;
        for (int i = 0; i < FAN; i++) begin
          if (j * FAN + i < NI) grp[j] = grp[j] & din[j * FAN + i];
        end
      end
    end

    // ---- tree level register ----
    always_ff @(posedge clk) begin
      if (en) dat_p <= grp;
    end

    always_ff @(posedge clk) begin
      if (rst)     vld_p <= 1'b0;
      else if (en) vld_p <= vld_in;
    end
  end

  assign root     = g_lvl[LEVELS-1].dat_p[0];
  assign vld_root = g_lvl[LEVELS-1].vld_p;

  always_comb begin
    hit_c = |root;
    idx_c = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (root[i]) idx_c = IDX_W'(i);
    end
  end

  // ---- encode stage register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_match <= '0;
      m_hit   <= 1'b0;
      m_index <= '0;
    end else if (en) begin
      m_valid <= vld_root;
      m_match <= root;
      m_hit   <= hit_c;
      m_index <= idx_c;
    end
  end

endmodule

// File: tb/tb_and_tree_pipe.sv
// Directed bench for and_tree_pipe: default configuration plus a small
// sweep of WIDTH/FAN configurations checked against a linear AND model.
module tb_and_tree_pipe;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid;
  logic          s_ready;
  logic [1023:0] s_in;
  logic [15:0]   s_slice_en;
  logic          m_valid;
  logic          m_ready;
  logic [63:0]   m_match;
  logic          m_hit;
  logic [5:0]    m_index;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  and_tree_pipe #(.DEPTH(64), .WIDTH(16), .FAN(6)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_in       (s_in),
    .s_slice_en (s_slice_en),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_match    (m_match),
    .m_hit      (m_hit),
    .m_index    (m_index)
  );

  // Sweep configurations: index 0..4 use FAN=2, 5..9 use FAN=6.
  function automatic int sw_w(int c);
    case (c % 5)
      0:       return 1;
      1:       return 6;
      2:       return 7;
      3:       return 36;
      default: return 37;
    endcase
  endfunction

  // Hand-derived LEVELS+1 for each sweep configuration.
  function automatic int sw_lat(int c);
    case (c)
      0: return 2;  1: return 4;  2: return 4;  3: return 7;  4: return 7;
      5: return 2;  6: return 2;  7: return 3;  8: return 3;  default: return 4;
    endcase
  endfunction

  logic [37*64-1:0] sw_pool;
  logic [36:0]      sw_en;
  logic             sw_svalid;
  logic [9:0]       sw_valid;
  logic [9:0]       sw_rdy;
  logic [9:0]       sw_hit;
  logic [63:0]      sw_match [10];
  logic [63:0]      sw_ref   [10];
  logic [5:0]       sw_idx   [10];

  for (genvar c = 0; c < 10; c++) begin : g_sw
    localparam int W = sw_w(c);
    localparam int F = (c < 5) ? 2 : 6;
    logic        srdy;
    logic        mv;
    logic        mh;
    logic [63:0] mm;
    logic [5:0]  mi;
    logic [63:0] ref_m;

    and_tree_pipe #(.DEPTH(64), .WIDTH(W), .FAN(F)) u_sw (
      .clk        (clk),
      .rst        (rst),
      .s_valid    (sw_svalid),
      .s_ready    (srdy),
      .s_in       (sw_pool[W*64-1:0]),
      .s_slice_en (sw_en[W-1:0]),
      .m_valid    (mv),
      .m_ready    (1'b1),
      .m_match    (mm),
      .m_hit      (mh),
      .m_index    (mi)
    );

    always_comb begin
      ref_m = '1;
      for (int k = 0; k < W; k++) begin
        if (sw_en[k]) ref_m = ref_m & sw_pool[k*64 +: 64];
      end
    end

    assign sw_valid[c] = mv;
    assign sw_rdy[c]   = srdy;
    assign sw_hit[c]   = mh;
    assign sw_match[c] = mm;
    assign sw_idx[c]   = mi;
    assign sw_ref[c]   = ref_m;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int low_idx(logic [63:0] v);
    for (int i = 0; i < 64; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic int idx_of(int v);
    return (v * 7) % 63;
  endfunction

  function automatic logic [63:0] slice_pat(int v);
    return (64'h1 << idx_of(v)) | (64'h1 << 63);
  endfunction

  function automatic logic [1023:0] vec_in(int v);
    logic [1023:0] r;
    r = '1;
    r[3*64 +: 64] = slice_pat(v);
    return r;
  endfunction

  task automatic send_wait(output int lat);
    lat = -1;
    s_valid = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (c == 1) s_valid = 1'b0;
      if (m_valid) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic run_stream(input int nvec, input int st0, input int stn, input int base,
                            output int first_c, output int last_c);
    int          expq[$];
    logic [63:0] held;
    int          sent;
    int          got;
    int          e;
    sent = 0; got = 0; first_c = -1; last_c = -1; held = '0;
    for (int c = 0; c < 80 && got < nvec; c++) begin
      m_ready = !(c >= st0 && c < st0 + stn);
      if (sent < nvec) begin
        s_valid = 1'b1;
        s_in    = vec_in(base + sent);
      end else begin
        s_valid = 1'b0;
      end
      #1;
      if (!m_ready) begin
        check("stall_s_ready", s_ready, 0);
        if (c == st0) held = m_match;
        else check("stall_hold", m_match, held);
      end
      if (s_valid && s_ready) begin
        expq.push_back(base + sent);
        sent++;
      end
      if (m_valid && m_ready) begin
        if (expq.size() == 0) begin
          check("unexpected_out", 1, 0);
        end else begin
          e = expq.pop_front();
          check("stream_match", m_match, slice_pat(e));
          check("stream_index", m_index, idx_of(e));
        end
        if (first_c < 0) first_c = c;
        last_c = c;
        got++;
      end
      @(posedge clk); #1;
    end
    check("stream_count", got, nvec);
    m_ready = 1'b1;
    s_valid = 1'b0;
  endtask

  initial begin
    int          lat;
    int          fc;
    int          lc;
    int          cnt;
    logic [9:0]  seen;
    logic [63:0] tmp;

    rst = 1'b1; s_valid = 1'b0; s_in = '1; s_slice_en = '1; m_ready = 1'b1;
    sw_svalid = 1'b0; sw_pool = '1; sw_en = '1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_m_valid", m_valid, 0);
    check("rst_m_match", m_match, 0);
    check("rst_m_hit",   m_hit, 0);
    check("rst_m_index", m_index, 0);
    check("rst_s_ready", s_ready, 1);
    check("rst_sw_ready", sw_rdy, 10'h3ff);

    // Slice 3 carries bits 5 and 40.
    s_in = '1;
    s_in[3*64 +: 64] = 64'h0000_0100_0000_0020;
    send_wait(lat);
    check("a_latency", lat, 3);
    check("a_match", m_match, 64'h0000_0100_0000_0020);
    check("a_hit", m_hit, 1);
    check("a_index", m_index, 5);

    s_slice_en[3] = 1'b0;
    send_wait(lat);
    check("b_latency", lat, 3);
    check("b_match", m_match, 64'hffff_ffff_ffff_ffff);
    check("b_hit", m_hit, 1);
    check("b_index", m_index, 0);

    s_slice_en = '1;
    s_in[15*64 +: 64] = 64'h0;
    send_wait(lat);
    check("c_latency", lat, 3);
    check("c_match", m_match, 0);
    check("c_hit", m_hit, 0);
    check("c_index", m_index, 0);
    @(posedge clk); #1;

    run_stream(10, 1000, 0, 0, fc, lc);
    check("d_first_latency", fc, 3);
    check("d_consecutive", lc - fc, 9);

    run_stream(8, 4, 5, 20, fc, lc);
    check("e_first_latency", fc, 3);

    // Two vectors in flight, then a one-cycle reset.
    s_valid = 1'b1; s_in = vec_in(50);
    @(posedge clk); #1;
    s_in = vec_in(51);
    @(posedge clk); #1;
    s_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("f_m_valid", m_valid, 0);
    check("f_m_match", m_match, 0);
    check("f_m_hit", m_hit, 0);
    check("f_s_ready", s_ready, 1);
    cnt = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (m_valid) cnt++;
    end
    check("f_flushed", cnt, 0);

    // Sweep: all disabled, all enabled, then random enables.
    for (int t = 0; t < 4; t++) begin
      for (int k = 0; k < 74; k++) sw_pool[k*32 +: 32] = $urandom | $urandom | $urandom;
      tmp = {$urandom, $urandom};
      if (t == 0)      sw_en = '0;
      else if (t == 1) sw_en = '1;
      else             sw_en = tmp[36:0];
      seen = '0;
      sw_svalid = 1'b1;
      for (int c = 1; c <= 10; c++) begin
        @(posedge clk); #1;
        if (c == 1) sw_svalid = 1'b0;
        for (int i = 0; i < 10; i++) begin
          if (sw_valid[i] && !seen[i]) begin
            seen[i] = 1'b1;
            check($sformatf("sw%0d_lat", i), c, sw_lat(i));
            check($sformatf("sw%0d_match", i), sw_match[i], sw_ref[i]);
            check($sformatf("sw%0d_hit", i), sw_hit[i], |sw_ref[i]);
            check($sformatf("sw%0d_index", i), sw_idx[i], low_idx(sw_ref[i]));
          end
        end
      end
      check("sw_all_seen", seen, 10'h3ff);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
